// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side drives hazard sources; the slave side returns hold/clear.
interface pipe_hazard_ctrl_if #(
    parameter int STAT_W = 16
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic              ex_branch_taken;
    logic              id_md_start;
    logic              id_md_div;
    logic              id_md_read;
    logic              mem_wait;
    logic              pc_hold;
    logic              ifid_hold;
    logic              ifid_clear;
    logic              idex_hold;
    logic              idex_clear;
    logic              exmem_hold;
    logic              memwb_clear;
    logic              md_busy;
    logic [STAT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_mem_read, ex_rt, ex_branch_taken,
        output id_md_start, id_md_div, id_md_read, mem_wait,
        input  pc_hold, ifid_hold, ifid_clear, idex_hold,
        input  idex_clear, exmem_hold, memwb_clear,
        input  md_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_mem_read, ex_rt, ex_branch_taken,
        input  id_md_start, id_md_div, id_md_read, mem_wait,
        output pc_hold, ifid_hold, ifid_clear, idex_hold,
        output idex_clear, exmem_hold, memwb_clear,
        output md_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush,
// memory-wait freeze and mult/div busy interlock, plus a stall counter.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter int STAT_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_MD  = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_md_cnt;
    logic [STAT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_md_lock;
    logic w_accept;
    logic w_pc_hold;
    logic w_ifid_hold;
    logic w_ifid_clear;
    logic w_idex_hold;
    logic w_idex_clear;
    logic w_exmem_hold;
    logic w_memwb_clear;

    assign w_load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                        ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                         (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

    assign w_md_lock = (r_state == S_MD) &&
                       (hz.id_md_read || hz.id_md_start);

    always_comb begin
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_clear  = 1'b0;
        w_idex_hold   = 1'b0;
        w_idex_clear  = 1'b0;
        w_exmem_hold  = 1'b0;
        w_memwb_clear = 1'b0;
        w_accept      = 1'b0;
        if (!rst_n) begin
            w_ifid_clear  = 1'b1;
            w_idex_clear  = 1'b1;
            w_memwb_clear = 1'b1;
        end else if (hz.mem_wait) begin
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_hold   = 1'b1;
            w_exmem_hold  = 1'b1;
            w_memwb_clear = 1'b1;
        end else if (hz.ex_branch_taken) begin
            w_ifid_clear = 1'b1;
            w_idex_clear = 1'b1;
        end else if (w_load_use || w_md_lock) begin
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_idex_clear = 1'b1;
        end else begin
            // md op only launches when it actually leaves ID this cycle
            w_accept = (r_state == S_RUN) && hz.id_md_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_md_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == S_MD) begin
                if (r_md_cnt == CNT_W'(1)) begin
                    r_state  <= S_RUN;
                    r_md_cnt <= '0;
                end else begin
                    r_md_cnt <= r_md_cnt - CNT_W'(1);
                end
            end else if (w_accept) begin
                r_state  <= S_MD;
                r_md_cnt <= hz.id_md_div ? CNT_W'(DIV_CYCLES)
                                         : CNT_W'(MUL_CYCLES);
            end
            if (w_pc_hold && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

    assign hz.pc_hold     = w_pc_hold;
    assign hz.ifid_hold   = w_ifid_hold;
    assign hz.ifid_clear  = w_ifid_clear;
    assign hz.idex_hold   = w_idex_hold;
    assign hz.idex_clear  = w_idex_clear;
    assign hz.exmem_hold  = w_exmem_hold;
    assign hz.memwb_clear = w_memwb_clear;
    assign hz.md_busy     = rst_n && (r_state == S_MD);
    assign hz.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a
// behavioural model (busy-cycles-remaining count, saturating stall total).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.STAT_W(16)) hz();

    pipe_hazard_ctrl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W(6),
        .STAT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int busy_rem = 0;
    int stall_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit lu_hit();
        return hz.ex_mem_read && hz.ex_rt != 0 &&
               ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) ||
                (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
    endfunction

    // {pc_h, ifid_h, ifid_c, idex_h, idex_c, exmem_h, memwb_c, md_busy}
    function automatic logic [7:0] exp_ctrl();
        logic [7:0] e;
        bit busy;
        busy = busy_rem > 0;
        if (!rst_n) return 8'b0010_1010;
        if (hz.mem_wait)             e = 8'b1101_0110;
        else if (hz.ex_branch_taken) e = 8'b0010_1000;
        else if (lu_hit() || (busy && (hz.id_md_read || hz.id_md_start)))
                                     e = 8'b1100_1000;
        else                         e = 8'b0000_0000;
        e[0] = busy;
        return e;
    endfunction

    function automatic bit exp_accept();
        return rst_n && !hz.mem_wait && !hz.ex_branch_taken && !lu_hit() &&
               busy_rem == 0 && hz.id_md_start;
    endfunction

    task automatic cycle();
        logic [7:0] e;
        logic [7:0] o;
        bit acc;
        @(negedge clk);
        e = exp_ctrl();
        acc = exp_accept();
        o = {hz.pc_hold, hz.ifid_hold, hz.ifid_clear, hz.idex_hold,
             hz.idex_clear, hz.exmem_hold, hz.memwb_clear, hz.md_busy};
        chk("ctrl", {24'd0, o}, {24'd0, e});
        chk("stall_cnt", {16'd0, hz.stall_cnt}, stall_m);
        @(posedge clk);
        if (!rst_n) begin
            busy_rem = 0;
            stall_m = 0;
        end else begin
            if (e[7] && stall_m < 65535) stall_m++;
            if (busy_rem > 0) busy_rem--;
            else if (acc) busy_rem = hz.id_md_div ? 32 : 4;
        end
        #1;
    endtask

    task automatic idle();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        hz.ex_mem_read = 0; hz.ex_rt = 0; hz.ex_branch_taken = 0;
        hz.id_md_start = 0; hz.id_md_div = 0; hz.id_md_read = 0;
        hz.mem_wait = 0;
    endtask

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            busy_rem = 0;
            stall_m = 0;
        end
    endtask

    task automatic load_use(input logic [4:0] rt);
        hz.ex_mem_read = 1; hz.ex_rt = rt; hz.id_rs = 8; hz.id_uses_rs = 1;
    endtask

    initial begin
        idle();
        cycle();
        cycle();
        set_rst(1'b1);
        cycle();

        // load-use and the r0 exemption
        load_use(5'd8); cycle();
        chk("lu_stall_cnt", {16'd0, hz.stall_cnt}, 32'd1);
        idle(); cycle();
        load_use(5'd0); cycle();
        idle(); cycle();

        // branch outranks load-use
        load_use(5'd8); hz.ex_branch_taken = 1; cycle();
        idle(); cycle();

        // mult then mfhi, then div then mfhi
        hz.id_md_start = 1; cycle();
        hz.id_md_start = 0; hz.id_md_read = 1;
        repeat (5) cycle();
        chk("mul_release", {31'd0, hz.pc_hold}, 32'd0);
        idle();
        hz.id_md_start = 1; hz.id_md_div = 1; cycle();
        hz.id_md_start = 0; hz.id_md_div = 0; hz.id_md_read = 1;
        repeat (33) cycle();
        idle(); cycle();

        // mem_wait inside mult busy window
        hz.id_md_start = 1; cycle();
        hz.id_md_start = 0; hz.id_md_read = 1; cycle();
        hz.mem_wait = 1; repeat (3) cycle();
        hz.mem_wait = 0; cycle();
        chk("mw_busy_end", {31'd0, hz.md_busy}, 32'd0);
        idle(); cycle();

        // branch squashes md start
        hz.id_md_start = 1; hz.ex_branch_taken = 1; cycle();
        idle(); cycle();
        chk("squash_busy", {31'd0, hz.md_busy}, 32'd0);

        // reset mid-div
        hz.id_md_start = 1; hz.id_md_div = 1; cycle();
        idle();
        hz.id_md_read = 1;
        repeat (9) cycle();
        set_rst(1'b0);
        #1;
        chk("rst_busy", {31'd0, hz.md_busy}, 32'd0);
        chk("rst_stall", {16'd0, hz.stall_cnt}, 32'd0);
        chk("rst_clear", {29'd0, hz.ifid_clear, hz.idex_clear,
                          hz.memwb_clear}, 32'd7);
        cycle();
        set_rst(1'b1);
        cycle();
        chk("post_rst_mfhi", {31'd0, hz.pc_hold}, 32'd0);
        idle(); cycle();

        // randomized traffic with occasional async reset
        for (int i = 0; i < 3000; i++) begin
            set_rst($urandom_range(0, 99) != 0);
            hz.id_rs = 5'($urandom_range(0, 3));
            hz.id_rt = 5'($urandom_range(0, 3));
            hz.id_uses_rs = 1'($urandom_range(0, 1));
            hz.id_uses_rt = 1'($urandom_range(0, 1));
            hz.ex_mem_read = ($urandom_range(0, 2) == 0);
            hz.ex_rt = 5'($urandom_range(0, 3));
            hz.ex_branch_taken = ($urandom_range(0, 6) == 0);
            hz.id_md_start = ($urandom_range(0, 4) == 0);
            hz.id_md_div = ($urandom_range(0, 3) == 0);
            hz.id_md_read = ($urandom_range(0, 3) == 0);
            hz.mem_wait = ($urandom_range(0, 5) == 0);
            cycle();
        end
        set_rst(1'b1);
        idle(); cycle();

        // saturation of the stall counter
        hz.mem_wait = 1;
        repeat (65536 + 5) cycle();
        chk("stall_sat", {16'd0, hz.stall_cnt}, 32'h0000_FFFF);
        idle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the hold and clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Handles load-use hazards, taken-branch flushes, data-memory wait freezes and a multi-cycle mult/div busy interlock. Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MUL_CYCLES, 4, cycles the mult unit is busy after a mult/multu is accepted
DIV_CYCLES, 32, cycles the div unit is busy after a div/divu is accepted
CNT_W, 6, width of the busy countdown; must hold max(MUL_CYCLES, DIV_CYCLES)
STAT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  destination register of the load in EX
ex_branch_taken  in  1  branch/jump resolved taken in EX
id_md_start  in  1  ID holds mult/multu/div/divu
id_md_div  in  1  qualifies id_md_start: 1 = div, 0 = mult
id_md_read  in  1  ID holds mfhi/mflo/mthi/mtlo
mem_wait  in  1  data memory not ready this cycle
pc_hold  out  1  hold PC
ifid_hold  out  1  hold IF/ID
ifid_clear  out  1  clear IF/ID to bubble
idex_hold  out  1  hold ID/EX
idex_clear  out  1  clear ID/EX to bubble
exmem_hold  out  1  hold EX/MEM
memwb_clear  out  1  clear MEM/WB to bubble
md_busy  out  1  mult/div unit busy
stall_cnt  out  STAT_W  saturating count of cycles with pc_hold=1

Behaviour:
- State: FSM {RUN, MD_BUSY}, busy countdown md_cnt[CNT_W], stall_cnt. rst_n low: state=RUN, md_cnt=0, stall_cnt=0, asynchronous; takes effect mid-operation, including during MD_BUSY.
- While rst_n low: all *_hold=0, ifid_clear=idex_clear=memwb_clear=1, md_busy=0.
- Control outputs are combinational from current state and inputs (stall acts in the same cycle). Exactly one priority case applies per cycle:
  1. mem_wait=1 (freeze): pc_hold=ifid_hold=idex_hold=exmem_hold=1, memwb_clear=1, all other outputs 0. Any pending branch/load-use/md event is re-evaluated once mem_wait drops. md_cnt keeps counting.
  2. ex_branch_taken=1: ifid_clear=1, idex_clear=1, no holds. The ID instruction is squashed; an id_md_start is NOT accepted.
  3. Interlock: (ex_mem_read && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt))), or (state==MD_BUSY && (id_md_read || id_md_start)): pc_hold=ifid_hold=1, idex_clear=1.
  4. Otherwise all holds/clears 0.
- MD accept: in RUN, id_md_start=1 and case 4 applies -> next edge: md_cnt=(id_md_div ? DIV_CYCLES : MUL_CYCLES), state=MD_BUSY. The instruction advances normally.
- MD_BUSY: md_cnt decrements every edge (including during mem_wait). When md_cnt==1 at an edge, the next state is RUN and md_cnt becomes 0. md_busy=1 exactly while state==MD_BUSY, i.e. for N cycles after the accept cycle. An mfhi in ID during the accept cycle+1 is released in cycle accept+N+1.
- A new md op is never accepted in MD_BUSY. It stalls under case 3 until RUN, then is accepted.
- stall_cnt increments on each edge where pc_hold=1. It saturates at all-ones and never wraps.
- ex_rt==0 never triggers a load-use stall.
- Multiple simultaneous conditions resolve strictly by priority 1>2>3>4. Outputs are never hold+clear on the same register.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> pc_hold=ifid_hold=idex_clear=1 for 1 cycle, stall_cnt 0->1. Same stimulus with ex_rt=0 -> no stall.
- Branch vs. load-use: ex_branch_taken=1 with a matching load-use -> ifid_clear=idex_clear=1, pc_hold=0, stall_cnt unchanged.
- Mult then mfhi: id_md_start=1, id_md_div=0 at cycle t, id_md_read=1 from t+1 -> md_busy high t+1..t+4, pc_hold high t+1..t+4, released t+5. With div: busy 32 cycles.
- mem_wait during MD_BUSY: 3-cycle mem_wait inside a mult busy window -> full freeze (memwb_clear=1) and md_busy still ends at t+4.
- Branch squashes md: id_md_start=1 with ex_branch_taken=1 -> state stays RUN, md_busy=0.
- Reset mid-div: assert rst_n=0 at busy cycle 10 -> md_busy=0 and stall_cnt=0 immediately, clears asserted. After release, an mfhi passes without stall. Separately, force 2^STAT_W+5 stall cycles -> stall_cnt holds at 16'hFFFF.
